// File: rtl/decoder_scan_n_pkg.sv
// Shared types and constants for the decoder_scan_n block.
// Optional blanking state is enabled with `define DECODER_SCAN_BLANK_EN.
package decoder_pkg;

    typedef enum logic [1:0] {
        S_DIRECT = 2'd0,
        S_SCAN   = 2'd1,
        S_BLANK  = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_scan_n_if.sv
// Control and output bundle of decoder_scan_n: enables, mode, address, dwell in;
// registered one-hot select, current address and wrap pulse out.
interface decoder_scan_n_if #(
    parameter int ADDR_W  = 3,
    parameter int DWELL_W = 8
);
    logic                     e1_n;
    logic                     e2_n;
    logic                     e3;
    logic                     mode;
    logic [ADDR_W-1:0]        addr;
    logic [DWELL_W-1:0]       dwell;
    logic [(1<<ADDR_W)-1:0]   y_n;
    logic [ADDR_W-1:0]        cur_addr;
    logic                     wrap;

    modport master (
        output e1_n, e2_n, e3, mode, addr, dwell,
        input  y_n, cur_addr, wrap
    );

    modport slave (
        input  e1_n, e2_n, e3, mode, addr, dwell,
        output y_n, cur_addr, wrap
    );
endinterface

// File: rtl/decoder_scan_n_onehot_dec_n.sv
// Combinational N-to-2^N active-low decoder; all outputs high when disabled.
module onehot_dec_n #(
    parameter int ADDR_W = 3
) (
    input  logic                   en,
    input  logic [ADDR_W-1:0]      addr,
    output logic [(1<<ADDR_W)-1:0] y_n
);

    always_comb begin
        y_n = '1;
        if (en) begin
            y_n[addr] = 1'b0;
        end
    end

endmodule

// File: rtl/decoder_scan_n.sv
// Registered active-low decoder with direct and dwell-timed scan modes.
// Define DECODER_SCAN_BLANK_EN to insert a one-cycle all-off gap between scan steps.
module decoder_scan_n
    import decoder_pkg::*;
#(
    parameter int ADDR_W  = 3,
    parameter int DWELL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    decoder_scan_n_if.slave   bus
);

    localparam int                OUT_W     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t              state, state_next;
    logic [DWELL_W-1:0]  cnt, cnt_next;
    logic [ADDR_W-1:0]   scan_addr, scan_next, scan_step;
    logic [ADDR_W-1:0]   cur_addr, cur_next;
    logic [OUT_W-1:0]    y_n, dec_y;
    logic                wrap, wrap_next;
    logic                en;
    logic                dec_en;
    logic [ADDR_W-1:0]   dec_addr;

    assign en        = bus.e3 & ~bus.e1_n & ~bus.e2_n;
    assign scan_step = scan_addr + ADDR_W'(1);

    onehot_dec_n #(.ADDR_W(ADDR_W)) u_dec (
        .en   (dec_en),
        .addr (dec_addr),
        .y_n  (dec_y)
    );

    // dec_en low yields the all-off pattern, so every "blank" case just leaves it at its default
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        scan_next  = scan_addr;
        cur_next   = cur_addr;
        wrap_next  = 1'b0;
        dec_en     = 1'b0;
        dec_addr   = scan_addr;

        if (bus.mode == MODE_DIRECT) begin
            state_next = S_DIRECT;
            dec_en     = en;
            dec_addr   = bus.addr;
            cur_next   = bus.addr;
        end else begin
            case (state)
                S_DIRECT: begin
                    state_next = S_SCAN;
                    cnt_next   = '0;
                    scan_next  = '0;
                    cur_next   = '0;
                    dec_en     = en;
                    dec_addr   = '0;
                end
                S_SCAN: begin
                    if (en) begin
                        // Counter free-runs past a lowered dwell until it wraps, so no step is skipped early
                        if (cnt != bus.dwell) begin
                            cnt_next = cnt + DWELL_W'(1);
                            dec_en   = 1'b1;
                            dec_addr = scan_addr;
                        end else begin
                            cnt_next  = '0;
                            scan_next = scan_step;
`ifdef DECODER_SCAN_BLANK_EN
                            state_next = S_BLANK;
`else
                            dec_en    = 1'b1;
                            dec_addr  = scan_step;
                            cur_next  = scan_step;
                            wrap_next = (scan_addr == LAST_ADDR);
`endif
                        end
                    end
                end
`ifdef DECODER_SCAN_BLANK_EN
                S_BLANK: begin
                    if (en) begin
                        state_next = S_SCAN;
                        cnt_next   = '0;
                        dec_en     = 1'b1;
                        dec_addr   = scan_addr;
                        cur_next   = scan_addr;
                        wrap_next  = (scan_addr == '0);
                    end
                end
`endif
                default: begin
                    state_next = S_DIRECT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_DIRECT;
            cnt       <= '0;
            scan_addr <= '0;
            cur_addr  <= '0;
            y_n       <= '1;
            wrap      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            scan_addr <= scan_next;
            cur_addr  <= cur_next;
            y_n       <= dec_y;
            wrap      <= wrap_next;
        end
    end

    assign bus.y_n      = y_n;
    assign bus.cur_addr = cur_addr;
    assign bus.wrap     = wrap;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Scoreboard bench for decoder_scan_n (ADDR_W=3, DWELL_W=8); follows DECODER_SCAN_BLANK_EN if defined.
module tb_decoder_scan_n;
    import decoder_pkg::*;

    typedef struct packed {
        logic [7:0] y;
        logic [2:0] cur;
        logic       wrap;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decoder_scan_n_if #(.ADDR_W(3), .DWELL_W(8)) bus ();

    decoder_scan_n #(.ADDR_W(3), .DWELL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: 0 direct, 1 scan, 2 blank
    int         m_state;
    logic [2:0] m_scan;
    logic [7:0] m_cnt;
    logic [7:0] m_y;
    logic [2:0] m_cur;
    logic       m_wrap;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] selectCode(input logic [2:0] a);
        return ~(8'd1 << a);
    endfunction

    task automatic modelReset();
        m_state = 0;
        m_scan  = 3'd0;
        m_cnt   = 8'd0;
        m_y     = 8'hFF;
        m_cur   = 3'd0;
        m_wrap  = 1'b0;
    endtask

    task automatic modelStep(input logic e1, input logic e2, input logic e3v, input logic md,
                             input logic [2:0] a, input logic [7:0] dw);
        logic en;
        en     = e3v && !e1 && !e2;
        m_wrap = 1'b0;
        if (md == MODE_DIRECT) begin
            m_state = 0;
            m_cur   = a;
            m_y     = en ? selectCode(a) : 8'hFF;
        end else if (m_state == 0) begin
            m_state = 1;
            m_scan  = 3'd0;
            m_cnt   = 8'd0;
            m_cur   = 3'd0;
            m_y     = en ? 8'hFE : 8'hFF;
        end else if (!en) begin
            m_y = 8'hFF;
        end else if (m_state == 2) begin
            m_state = 1;
            m_cnt   = 8'd0;
            m_cur   = m_scan;
            m_y     = selectCode(m_scan);
            m_wrap  = (m_scan == 3'd0);
        end else if (m_cnt == dw) begin
            m_cnt = 8'd0;
`ifdef DECODER_SCAN_BLANK_EN
            m_scan  = m_scan + 3'd1;
            m_state = 2;
            m_y     = 8'hFF;
`else
            m_wrap = (m_scan == 3'd7);
            m_scan = m_scan + 3'd1;
            m_cur  = m_scan;
            m_y    = selectCode(m_scan);
`endif
        end else begin
            m_cnt = m_cnt + 8'd1;
            m_y   = selectCode(m_scan);
        end
    endtask

    task automatic applyStimulus(input logic e1, input logic e2, input logic e3v, input logic md,
                                 input logic [2:0] a, input logic [7:0] dw);
        exp_t e;
        bus.e1_n  = e1;
        bus.e2_n  = e2;
        bus.e3    = e3v;
        bus.mode  = md;
        bus.addr  = a;
        bus.dwell = dw;
        modelStep(e1, e2, e3v, md, a, dw);
        e.y    = m_y;
        e.cur  = m_cur;
        e.wrap = m_wrap;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checkOutput("y_n", {24'd0, bus.y_n}, {24'd0, e.y});
        checkOutput("cur_addr", {29'd0, bus.cur_addr}, {29'd0, e.cur});
        checkOutput("wrap", {31'd0, bus.wrap}, {31'd0, e.wrap});
    endtask

    initial begin
        int first_wrap;
        int wraps;
        bit found;

        rst_n     = 1'b0;
        bus.e1_n  = 1'b1;
        bus.e2_n  = 1'b1;
        bus.e3    = 1'b0;
        bus.mode  = MODE_DIRECT;
        bus.addr  = 3'd0;
        bus.dwell = 8'd0;
        modelReset();
        #12;
        checkOutput("reset_y_n", {24'd0, bus.y_n}, 32'hFF);
        checkOutput("reset_cur_addr", {29'd0, bus.cur_addr}, 32'd0);
        checkOutput("reset_wrap", {31'd0, bus.wrap}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Direct decoding and enable gating
        applyStimulus(0, 0, 1, MODE_DIRECT, 3'd5, 8'd0);
        checkOutput("direct_addr5", {24'd0, bus.y_n}, 32'hDF);
        applyStimulus(0, 0, 0, MODE_DIRECT, 3'd5, 8'd0);
        checkOutput("direct_e3_low", {24'd0, bus.y_n}, 32'hFF);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, MODE_DIRECT, i[2:0], 8'd0);
        applyStimulus(1, 0, 1, MODE_DIRECT, 3'd2, 8'd0);
        applyStimulus(0, 1, 1, MODE_DIRECT, 3'd3, 8'd0);

        // Scan with dwell 2: wrap expected on the 25th scan cycle
        first_wrap = 0;
        for (int c = 1; c <= 30; c++) begin
            applyStimulus(0, 0, 1, MODE_SCAN, 3'd0, 8'd2);
            if (bus.wrap === 1'b1 && first_wrap == 0) first_wrap = c;
        end
`ifndef DECODER_SCAN_BLANK_EN
        checkOutput("dwell2_wrap_cycle", first_wrap, 32'd25);
`endif

        // Scan with dwell 0: wraps on scan cycles 9 and 17
        applyStimulus(0, 0, 1, MODE_DIRECT, 3'd0, 8'd0);
        wraps = 0;
        for (int c = 1; c <= 24; c++) begin
            applyStimulus(0, 0, 1, MODE_SCAN, 3'd0, 8'd0);
            if (bus.wrap === 1'b1) wraps++;
        end
`ifndef DECODER_SCAN_BLANK_EN
        checkOutput("dwell0_wrap_count", wraps, 32'd2);
`endif

        // Freeze at address 3 while disabled, then finish its dwell
        applyStimulus(0, 0, 1, MODE_DIRECT, 3'd0, 8'd0);
        for (int c = 1; c <= 11; c++) applyStimulus(0, 0, 1, MODE_SCAN, 3'd0, 8'd2);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1, 0, 1, MODE_SCAN, 3'd0, 8'd2);
            checkOutput("freeze_y_n", {24'd0, bus.y_n}, 32'hFF);
`ifndef DECODER_SCAN_BLANK_EN
            checkOutput("freeze_cur_addr", {29'd0, bus.cur_addr}, 32'd3);
`endif
        end
        applyStimulus(0, 0, 1, MODE_SCAN, 3'd0, 8'd2);
`ifndef DECODER_SCAN_BLANK_EN
        checkOutput("resume_addr3", {24'd0, bus.y_n}, 32'hF7);
`endif
        applyStimulus(0, 0, 1, MODE_SCAN, 3'd0, 8'd2);
`ifndef DECODER_SCAN_BLANK_EN
        checkOutput("resume_addr4", {24'd0, bus.y_n}, 32'hEF);
`endif

        // Drop to direct mid-scan, then restart scanning from 0
        applyStimulus(0, 0, 1, MODE_DIRECT, 3'd6, 8'd2);
        checkOutput("midscan_direct6", {24'd0, bus.y_n}, 32'hBF);
        applyStimulus(0, 0, 1, MODE_SCAN, 3'd6, 8'd5);
        checkOutput("rescan_start", {24'd0, bus.y_n}, 32'hFE);

        // Lower dwell below the running counter: step only after counter wraps
        for (int c = 0; c < 3; c++) applyStimulus(0, 0, 1, MODE_SCAN, 3'd0, 8'd5);
        for (int c = 0; c < 254; c++) applyStimulus(0, 0, 1, MODE_SCAN, 3'd0, 8'd1);
        checkOutput("lowered_dwell_hold", {29'd0, bus.cur_addr}, 32'd0);
        applyStimulus(0, 0, 1, MODE_SCAN, 3'd0, 8'd1);

`ifdef DECODER_SCAN_BLANK_EN
        // Blank pattern with dwell 1: FE FE FF FD FD FF
        applyStimulus(0, 0, 1, MODE_DIRECT, 3'd0, 8'd1);
        begin
            logic [7:0] pattern [6];
            pattern = '{8'hFE, 8'hFE, 8'hFF, 8'hFD, 8'hFD, 8'hFF};
            for (int c = 0; c < 6; c++) begin
                applyStimulus(0, 0, 1, MODE_SCAN, 3'd0, 8'd1);
                checkOutput("blank_pattern", {24'd0, bus.y_n}, {24'd0, pattern[c]});
            end
        end
`endif

        // Async reset landing on a wrap cycle must clear everything at once
        applyStimulus(0, 0, 1, MODE_DIRECT, 3'd0, 8'd0);
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            applyStimulus(0, 0, 1, MODE_SCAN, 3'd0, 8'd0);
            if (bus.wrap === 1'b1) found = 1'b1;
        end
        checkOutput("wrap_seen_before_reset", {31'd0, found}, 32'd1);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_reset_y_n", {24'd0, bus.y_n}, 32'hFF);
        checkOutput("async_reset_cur_addr", {29'd0, bus.cur_addr}, 32'd0);
        checkOutput("async_reset_wrap", {31'd0, bus.wrap}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic against the model
        for (int c = 0; c < 400; c++) begin
            applyStimulus(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 9) != 0), ($urandom_range(0, 15) != 0),
                          3'($urandom_range(0, 7)), 8'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
